decode_ctrl_fsm: RTL and testbench
==================================

DECODE_CTRL_FSM -- requirements
Module: decode_ctrl_fsm

Interface
REQ-001 Parameter IW, default 9: instruction width in bits, minimum 5.
REQ-002 Parameter OPW, default 3: opcode width, taken from Instruction[IW-1:IW-OPW].
REQ-003 Parameter MEM_LAT, default 1: data-memory access latency in cycles, minimum 1.
REQ-004 Clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Reset  input  1: asynchronous, active-high reset.
REQ-006 Start  input  1: begin or restart program execution.
REQ-007 Instruction  input  IW: machine code from instruction ROM.
REQ-008 InstrValid  input  1: Instruction is meaningful this cycle.
REQ-009 Zero  input  1: ALU zero flag for the current instruction.
REQ-010 Jump, BranchEn, RegWrEn, MemWrEn, LoadInst, StoreInst  output  1 each: registered control strobes.
REQ-011 TargSel  output  2: registered LUT select, equal to Instruction[3:2].
REQ-012 Stall  output  1: hold the program counter.
REQ-013 Ack  output  1: program done, sticky.
REQ-014 Busy  output  1: high in RUN and MEMWAIT.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, MEMWAIT, DONE.
REQ-016 IDLE: all outputs 0; Start=1 moves to RUN on the next edge.
REQ-017 RUN with InstrValid=1: the instruction SHALL be decoded, with strobes valid on the cycle after capture (latency 1).
REQ-018 RUN with InstrValid=0: all strobes SHALL be 0 on the next cycle (bubble); state is unchanged.
REQ-019 Opcode OP_ST (3'b110 at OPW=3): MemWrEn=StoreInst=1 and RegWrEn=0.
REQ-020 Opcode OP_LD (3'b011): LoadInst=1, with RegWrEn deferred per REQ-024.
REQ-021 Other opcodes: RegWrEn=1 unless Instruction[IW-1:IW-2]==2'b11.
REQ-022 Jump SHALL be 1 only when Instruction[2:0]==kRSH and Zero=1; this conditional behaviour is new.
REQ-023 BranchEn SHALL be 1 when Instruction[3:0]==4'hF and the instruction is not ACK.
REQ-024 Load or store with MEM_LAT>1:
- enter MEMWAIT with the wait counter loaded to MEM_LAT-1.
- Stall=1 for every MEMWAIT cycle.
- the counter decrements each cycle.
- on reaching 0, return to RUN.
- for loads, RegWrEn pulses for exactly one cycle, on the last MEMWAIT cycle.
REQ-025 With MEM_LAT=1, MEMWAIT SHALL never be entered, Stall stays 0, and load RegWrEn is asserted with LoadInst.
REQ-026 In MEMWAIT, Instruction and InstrValid SHALL be ignored, and MemWrEn is high only on the first strobe cycle.
REQ-027 Instruction all ones (ACK) in RUN: go to DONE, Ack=1, all strobes 0.
REQ-028 In DONE, Ack SHALL stay 1 and InstrValid is ignored; Start=1 clears Ack and enters RUN on the next edge.
REQ-029 Start SHALL be ignored in RUN and MEMWAIT.
REQ-030 Simultaneous ACK and Start in RUN: ACK wins.
REQ-031 TargSel SHALL update with every valid decode and hold its value otherwise.

Reset
REQ-032 Reset=1 SHALL immediately force:
- state IDLE and wait counter 0.
- all outputs 0, Ack included.
REQ-033 Reset in any state, including mid-MEMWAIT, SHALL abort the pending access with no further strobe.
REQ-034 Start is honoured from the first edge after Reset deasserts.

Structure
REQ-035 The shared package definitions SHALL hold the following:
- state enum.
- OP_LD, OP_ST and kRSH.
- BRANCH_PATTERN.
REQ-036 The wait counter SHALL be a sub-module mem_wait_cnt, parametrised by MEM_LAT and with width $clog2(MEM_LAT+1).
REQ-037 No combinational path SHALL exist from Instruction to any output.

Verification
REQ-038 Reset, then Start, then valid 9'b000_000_001 (ALU op): RegWrEn=1 one cycle later, all other strobes 0.
REQ-039 MEM_LAT=3, load 9'b011_000_000: the following SHALL hold:
- LoadInst=1.
- Stall=1 for 2 cycles.
- RegWrEn=1 only on the 2nd Stall cycle.
- then back in RUN.
REQ-040 kRSH instruction with Zero=0: Jump=0; the same instruction with Zero=1: Jump=1.
REQ-041 ACK 9'h1FF: Ack=1 and held for 10 cycles despite valid instructions; Start then gives Ack=0 and Busy=1.
REQ-042 Store with MEM_LAT=3, then Reset asserted in the 2nd MEMWAIT cycle: all outputs 0 immediately, state IDLE.
REQ-043 InstrValid=0 for 3 cycles in RUN: all strobes 0, and TargSel holds its prior value.

Source files
------------

// File: rtl/decode_ctrl_fsm_pkg.sv
// Shared definitions for the instruction decode controller.
//   state_t          : controller state encoding (also exported on dbg_state)
//   strobes_t        : bundle of registered control strobes
//   OP_LD / OP_ST    : load / store opcodes (top OPW bits of the instruction)
//   kRSH             : low-bit pattern of the conditional-jump instruction
//   BRANCH_PATTERN   : low nibble that marks a branch instruction
package decode_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] OP_LD          = 3'b011;
  localparam logic [2:0] OP_ST          = 3'b110;
  localparam logic [2:0] kRSH           = 3'b100;
  localparam logic [3:0] BRANCH_PATTERN = 4'hF;

  typedef struct packed {
    logic       jump;
    logic       branch_en;
    logic       reg_wr_en;
    logic       mem_wr_en;
    logic       load_inst;
    logic       store_inst;
    logic [1:0] targ_sel;
  } strobes_t;

endpackage

// File: rtl/decode_ctrl_fsm_mem_wait_cnt.sv
// Data-memory wait counter.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load       : load the count with MEM_LAT-1
//   dec        : decrement by one (saturates at 0)
//   last       : count is 1 (final wait cycle)
//   near_last  : count is 2 (the next cycle is the final wait cycle)
module mem_wait_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last,
  output logic near_last
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last      = (cnt == CW'(1));
  // Widened compare so that a 1-bit counter (MEM_LAT=1) never aliases 2 onto 0.
  assign near_last = (32'(cnt) == 32'd2);

endmodule

// File: rtl/decode_ctrl_fsm.sv
// Instruction decode controller.
//   Clk, Reset      : clock, asynchronous active-high reset
//   Start           : begin / restart execution (honoured in IDLE and DONE)
//   Instruction     : instruction word, InstrValid qualifies it
//   Zero            : ALU zero flag, qualifies the conditional jump
//   Jump .. StoreInst, TargSel : registered control strobes (1-cycle latency)
//   Stall           : hold the PC while a multi-cycle memory access completes
//   Ack             : program finished (sticky until Start)
//   Busy            : executing (RUN or MEMWAIT)
//   dbg_state       : current controller state
// Handshake: an instruction is consumed on every rising edge in RUN where
// InstrValid=1; there is no back-pressure other than Stall, during which the
// instruction inputs are ignored.
module decode_ctrl_fsm
  import decode_ctrl_fsm_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPW     = 3,
  parameter int MEM_LAT = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instruction,
  input  logic          InstrValid,
  input  logic          Zero,
  output logic          Jump,
  output logic          BranchEn,
  output logic          RegWrEn,
  output logic          MemWrEn,
  output logic          LoadInst,
  output logic          StoreInst,
  output logic [1:0]    TargSel,
  output logic          Stall,
  output logic          Ack,
  output logic          Busy,
  output state_t        dbg_state
);

  localparam bit MULTI_CYCLE = (MEM_LAT > 1);

  state_t   state_q, state_d;
  strobes_t str_q, str_d;
  logic     mem_is_load_q, mem_is_load_d;
  logic     cnt_load, cnt_dec, cnt_last, cnt_near_last;

  logic [OPW-1:0] opcode;
  logic           is_ack, is_ld, is_st, no_reg_wr;

  assign opcode    = Instruction[IW-1:IW-OPW];
  assign is_ack    = &Instruction;
  assign is_ld     = (opcode == OPW'(OP_LD));
  assign is_st     = (opcode == OPW'(OP_ST));
  assign no_reg_wr = (Instruction[IW-1:IW-2] == 2'b11);

  mem_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .last      (cnt_last),
    .near_last (cnt_near_last)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      str_q         <= '0;
      mem_is_load_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      str_q         <= str_d;
      mem_is_load_q <= mem_is_load_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    str_d             = '0;
    str_d.targ_sel    = str_q.targ_sel;
    mem_is_load_d     = mem_is_load_q;
    cnt_load          = 1'b0;
    cnt_dec           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_RUN;
      end

      S_RUN: begin
        // ACK takes priority over everything, Start included.
        if (InstrValid) begin
          if (is_ack) begin
            state_d = S_DONE;
          end else begin
            str_d.targ_sel  = Instruction[3:2];
            str_d.jump      = (Instruction[2:0] == kRSH) && Zero;
            str_d.branch_en = (Instruction[3:0] == BRANCH_PATTERN);
            if (is_st) begin
              str_d.mem_wr_en  = 1'b1;
              str_d.store_inst = 1'b1;
            end else if (is_ld) begin
              str_d.load_inst = 1'b1;
              str_d.reg_wr_en = (MEM_LAT == 1);
            end else begin
              str_d.reg_wr_en = !no_reg_wr;
            end
            if ((is_ld || is_st) && MULTI_CYCLE) begin
              state_d       = S_MEMWAIT;
              cnt_load      = 1'b1;
              mem_is_load_d = is_ld;
              // With a single wait cycle the load write-back coincides with it.
              str_d.reg_wr_en = is_ld && (MEM_LAT == 2);
            end
          end
        end
      end

      S_MEMWAIT: begin
        cnt_dec = 1'b1;
        // Register the write-back so it lands on the final wait cycle.
        str_d.reg_wr_en = mem_is_load_q && cnt_near_last;
        if (cnt_last) state_d = S_RUN;
      end

      S_DONE: begin
        if (Start) state_d = S_RUN;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign Jump      = str_q.jump;
  assign BranchEn  = str_q.branch_en;
  assign RegWrEn   = str_q.reg_wr_en;
  assign MemWrEn   = str_q.mem_wr_en;
  assign LoadInst  = str_q.load_inst;
  assign StoreInst = str_q.store_inst;
  assign TargSel   = str_q.targ_sel;
  assign Stall     = (state_q == S_MEMWAIT);
  assign Ack       = (state_q == S_DONE);
  assign Busy      = (state_q == S_RUN) || (state_q == S_MEMWAIT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_decode_ctrl_fsm.sv
// Directed bench for decode_ctrl_fsm: one instance with MEM_LAT=3 and one
// with MEM_LAT=1. Output vectors are packed as
// {Jump,BranchEn,RegWrEn,MemWrEn,LoadInst,StoreInst,TargSel[1:0],Stall,Ack,Busy}.
module tb_decode_ctrl_fsm;
  import decode_ctrl_fsm_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT with MEM_LAT=3 ----------------
  logic       start, ivalid, zero;
  logic [8:0] instr;
  logic       jump, branch_en, reg_wr_en, mem_wr_en, load_inst, store_inst;
  logic [1:0] targ_sel;
  logic       stall, ack, busy;
  state_t     st;

  decode_ctrl_fsm #(.IW(9), .OPW(3), .MEM_LAT(3)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Instruction(instr),
    .InstrValid(ivalid), .Zero(zero), .Jump(jump), .BranchEn(branch_en),
    .RegWrEn(reg_wr_en), .MemWrEn(mem_wr_en), .LoadInst(load_inst),
    .StoreInst(store_inst), .TargSel(targ_sel), .Stall(stall), .Ack(ack),
    .Busy(busy), .dbg_state(st)
  );

  // ---------------- DUT with MEM_LAT=1 ----------------
  logic       start1, ivalid1;
  logic [8:0] instr1;
  logic       jump1, branch_en1, reg_wr_en1, mem_wr_en1, load_inst1, store_inst1;
  logic [1:0] targ_sel1;
  logic       stall1, ack1, busy1;
  state_t     st1;

  decode_ctrl_fsm #(.IW(9), .OPW(3), .MEM_LAT(1)) dut1 (
    .Clk(clk), .Reset(rst), .Start(start1), .Instruction(instr1),
    .InstrValid(ivalid1), .Zero(zero), .Jump(jump1), .BranchEn(branch_en1),
    .RegWrEn(reg_wr_en1), .MemWrEn(mem_wr_en1), .LoadInst(load_inst1),
    .StoreInst(store_inst1), .TargSel(targ_sel1), .Stall(stall1), .Ack(ack1),
    .Busy(busy1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  function automatic logic [10:0] outs();
    return {jump, branch_en, reg_wr_en, mem_wr_en, load_inst, store_inst,
            targ_sel, stall, ack, busy};
  endfunction

  function automatic logic [10:0] outs1();
    return {jump1, branch_en1, reg_wr_en1, mem_wr_en1, load_inst1, store_inst1,
            targ_sel1, stall1, ack1, busy1};
  endfunction

  function automatic logic [10:0] ev(input logic j, input logic b, input logic r,
                                     input logic m, input logic l, input logic s,
                                     input logic [1:0] t, input logic sl,
                                     input logic a, input logic bz);
    return {j, b, r, m, l, s, t, sl, a, bz};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; ivalid = 1'b0; zero = 1'b0; instr = '0;
    start1 = 1'b0; ivalid1 = 1'b0; instr1 = '0;
    #1;
    chk("reset_outs", 32'(outs()), 32'(11'b0));
    chk("reset_state", 32'(st), 32'(S_IDLE));
    tick(); tick();
    rst = 1'b0;

    // Idle holds without Start
    tick();
    chk("idle_outs", 32'(outs()), 32'(11'b0));

    // Start -> RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_run", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b00,0,0,1)));
    chk("start_state", 32'(st), 32'(S_RUN));

    // ALU op
    instr = 9'b000_000_001; ivalid = 1'b1;
    tick();
    chk("alu_op", 32'(outs()), 32'(ev(0,0,1,0,0,0,2'b00,0,0,1)));

    // ALU op with TargSel=2
    instr = 9'b000_001_000;
    tick();
    chk("alu_targ", 32'(outs()), 32'(ev(0,0,1,0,0,0,2'b10,0,0,1)));

    // Bubbles: strobes clear, TargSel holds
    ivalid = 1'b0; instr = 9'b111_111_110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b10,0,0,1)));
    end

    // Branch
    ivalid = 1'b1; instr = 9'b000_001_111;
    tick();
    chk("branch", 32'(outs()), 32'(ev(0,1,1,0,0,0,2'b11,0,0,1)));

    // kRSH with Zero=0 then Zero=1
    instr = 9'b000_000_100; zero = 1'b0;
    tick();
    chk("rsh_z0", 32'(outs()), 32'(ev(0,0,1,0,0,0,2'b01,0,0,1)));
    zero = 1'b1;
    tick();
    chk("rsh_z1", 32'(outs()), 32'(ev(1,0,1,0,0,0,2'b01,0,0,1)));
    zero = 1'b0;

    // Top bits 11 (not ACK, not store): no register write
    instr = 9'b111_000_000;
    tick();
    chk("op111_nowr", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b00,0,0,1)));

    // Load with MEM_LAT=3
    instr = 9'b011_000_000;
    tick();
    chk("ld_first", 32'(outs()), 32'(ev(0,0,0,0,1,0,2'b00,1,0,1)));
    chk("ld_state", 32'(st), 32'(S_MEMWAIT));
    instr = 9'b000_001_001;
    tick();
    chk("ld_wait2", 32'(outs()), 32'(ev(0,0,1,0,0,0,2'b00,1,0,1)));
    tick();
    chk("ld_back", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b00,0,0,1)));
    chk("ld_back_state", 32'(st), 32'(S_RUN));
    tick();
    chk("after_ld", 32'(outs()), 32'(ev(0,0,1,0,0,0,2'b10,0,0,1)));

    // Start ignored in RUN
    start = 1'b1; ivalid = 1'b0;
    tick();
    start = 1'b0;
    chk("start_in_run", 32'(st), 32'(S_RUN));
    chk("start_in_run_o", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b10,0,0,1)));

    // ACK together with Start: ACK wins
    instr = 9'h1FF; ivalid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ack", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b10,0,1,0)));
    chk("ack_state", 32'(st), 32'(S_DONE));

    // Ack sticky despite valid instructions
    instr = 9'b000_000_001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ack_hold", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b10,0,1,0)));
    end

    // Start from DONE
    ivalid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b10,0,0,1)));

    // Store, then reset in second wait cycle
    instr = 9'b110_000_100; ivalid = 1'b1;
    tick();
    chk("st_first", 32'(outs()), 32'(ev(0,0,0,1,0,1,2'b01,1,0,1)));
    tick();
    chk("st_wait2", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b01,1,0,1)));
    rst = 1'b1;
    #1;
    chk("st_reset_o", 32'(outs()), 32'(11'b0));
    chk("st_reset_state", 32'(st), 32'(S_IDLE));
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset", 32'(outs()), 32'(11'b0));

    // Start honoured right after reset release
    ivalid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_after_rst", 32'(outs()), 32'(ev(0,0,0,0,0,0,2'b00,0,0,1)));

    // ---------------- MEM_LAT=1 instance ----------------
    chk("d1_idle", 32'(st1), 32'(S_IDLE));
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    instr1 = 9'b011_000_000; ivalid1 = 1'b1;
    tick();
    chk("d1_load", 32'(outs1()), 32'(ev(0,0,1,0,1,0,2'b00,0,0,1)));
    chk("d1_load_state", 32'(st1), 32'(S_RUN));
    instr1 = 9'b110_001_000;
    tick();
    chk("d1_store", 32'(outs1()), 32'(ev(0,0,0,1,0,1,2'b10,0,0,1)));
    chk("d1_store_state", 32'(st1), 32'(S_RUN));
    ivalid1 = 1'b0;
    tick();
    chk("d1_bubble", 32'(outs1()), 32'(ev(0,0,0,0,0,0,2'b10,0,0,1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
